// File: rtl/fir_tap_accumulator.sv
// Serial tap accumulator: sums TAPS signed products, rounds and scales by 2^-FRAC to 16 bits.
// Optional output saturation with a sticky overflow flag when SAT_EN is defined.
module fir_tap_accumulator #(
   parameter int TAPS  = 32,
   parameter int ACC_W = 40,
   parameter int FRAC  = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        valid_in,
   input  logic [31:0] mul_in,
   output logic [15:0] data_out,
   output logic        valid_out,
   output logic        busy,
   output logic        ovf
);

   localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam int R_W   = ACC_W + 1 - FRAC;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TAPS - 1);
   localparam logic [ACC_W:0]   HALF     = (ACC_W + 1)'(1) << (FRAC - 1);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      data_q, data_d;
   logic             valid_q, valid_d;

   logic [CNT_W-1:0] eff_cnt;
   logic [ACC_W-1:0] sum;
   logic [ACC_W:0]   rnd;
   logic [R_W-1:0]   r;
   logic [15:0]      fmt;
   logic             clip;

   // Rounding adds one guard bit so the half-LSB bias can never wrap the sum.
   always_comb begin
      eff_cnt = start ? '0 : cnt_q;
      sum     = (start ? '0 : acc_q) + {{(ACC_W-32){mul_in[31]}}, mul_in};
      rnd     = {sum[ACC_W-1], sum} + HALF;
      r       = rnd[ACC_W:FRAC];
   end

`ifdef SAT_EN
   logic ovf_q, ovf_d;

   // Any disagreement among the bits above bit 15 means r is outside int16.
   always_comb begin
      clip = ~((&r[R_W-1:15]) | ~(|r[R_W-1:15]));
      if (clip) fmt = r[R_W-1] ? 16'h8000 : 16'h7FFF;
      else      fmt = r[15:0];
   end

   always_ff @(posedge clk) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= ovf_d;
   end

   always_comb begin
      ovf_d = ovf_q;
      if (valid_in && (eff_cnt == LAST_CNT) && clip) ovf_d = 1'b1;
   end

   assign ovf = ovf_q;
`else
   always_comb begin
      clip = 1'b0;
      fmt  = r[15:0];
   end

   assign ovf = 1'b0;
`endif

   always_comb begin
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      valid_d = 1'b0;
      if (valid_in) begin
         if (eff_cnt == LAST_CNT) begin
            acc_d   = '0;
            cnt_d   = '0;
            data_d  = fmt;
            valid_d = 1'b1;
         end else begin
            acc_d = sum;
            cnt_d = eff_cnt + CNT_W'(1);
         end
      end else if (start) begin
         acc_d = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign busy      = (cnt_q != '0);

endmodule
